life_tracker: RTL and testbench

Game-state block that owns both players' life counts and drives the `lives1`/`lives2` buses consumed by the seven-segment lives display. It takes per-player hit indications from the collision logic, edge-detects them, enforces a per-player invulnerability cooldown, decrements lives, and declares a winner or draw when a count reaches zero. It sits between the collision/fight logic and the display driver, all in the single system clock domain.

---
 rtl/life_tracker_pkg.sv | 10 +
 rtl/life_tracker_hit_gate.sv | 29 ++
 rtl/life_tracker.sv | 60 ++++++
 tb/tb_life_tracker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/life_tracker_pkg.sv
// life_tracker_pkg: shared game types (FSM states, winner codes, lives type)
package life_tracker_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    typedef logic [1:0] lives_t;
    typedef logic [1:0] winner_t;
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;
    localparam winner_t WIN_DRAW = 2'b11;
endpackage

// File: rtl/life_tracker_hit_gate.sv
// hit_gate: per-player hit edge detect with invulnerability hold-off.
// Ports: clk, rst (sync, active high), enable (accept allowed), clear (zero hold-off),
// hit (level from collision logic), accept (one-cycle accepted-hit pulse).
module hit_gate #(
    parameter int COOLDOWN = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic hit,
    output logic accept
);
    localparam int W = $clog2(COOLDOWN + 1);
    logic         prev;
    logic [W-1:0] cnt;
    assign accept = enable && hit && !prev && cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= hit;
            // The accepting cycle counts as the first hold-off cycle, so the
            // next hit can land exactly COOLDOWN edges after this one.
            cnt  <= clear ? '0 : accept ? W'(COOLDOWN - 1) : cnt != '0 ? cnt - 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/life_tracker.sv
// life_tracker: round FSM owning both players' lives, winner and draw detection.
// Ports: clk, rst (sync, active high), start (round start pulse), hit1/hit2 (strike levels),
// lives1/lives2 (registered remaining lives), playing, game_over, winner (valid in OVER).
module life_tracker
    import life_tracker_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int COOLDOWN    = 25_000_000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  logic    hit1,
    input  logic    hit2,
    output lives_t  lives1,
    output lives_t  lives2,
    output logic    playing,
    output logic    game_over,
    output winner_t winner
);
    localparam lives_t INIT = lives_t'(START_LIVES);
    state_t state;
    logic   a1, a2, go, fin1, fin2;
    // A start is only taken outside PLAY; its own cycle never accepts a hit.
    assign go   = start && state != PLAY;
    assign fin1 = a1 && lives1 == 2'd1;
    assign fin2 = a2 && lives2 == 2'd1;
    hit_gate #(.COOLDOWN(COOLDOWN)) g1 (
        .clk(clk), .rst(rst), .enable(state == PLAY), .clear(go), .hit(hit1), .accept(a1)
    );
    hit_gate #(.COOLDOWN(COOLDOWN)) g2 (
        .clk(clk), .rst(rst), .enable(state == PLAY), .clear(go), .hit(hit2), .accept(a2)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lives1    <= INIT;
            lives2    <= INIT;
            playing   <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else if (state == PLAY) begin
            lives1 <= lives1 - lives_t'(a1 && lives1 != '0);
            lives2 <= lives2 - lives_t'(a2 && lives2 != '0);
            if (fin1 || fin2) begin
                state     <= OVER;
                playing   <= 1'b0;
                game_over <= 1'b1;
                winner    <= fin1 && fin2 ? WIN_DRAW : fin1 ? WIN_P2 : WIN_P1;
            end
        end else if (go) begin
            state     <= PLAY;
            lives1    <= INIT;
            lives2    <= INIT;
            playing   <= 1'b1;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end
    end
endmodule

// File: tb/tb_life_tracker.sv
// tb_life_tracker: directed self-checking bench for life_tracker (START_LIVES=3, COOLDOWN=4)
module tb_life_tracker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hit1 = 1'b0;
    logic       hit2 = 1'b0;
    logic [1:0] lives1, lives2, winner;
    logic       playing, game_over;
    int         nvec = 0;
    int         nerr = 0;

    life_tracker #(.START_LIVES(3), .COOLDOWN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .hit1(hit1), .hit2(hit2),
        .lives1(lives1), .lives2(lives2), .playing(playing),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] l1, input logic [1:0] l2,
                           input logic p, input logic g, input logic [1:0] w);
        chk({tag, ".lives1"}, 8'(lives1), 8'(l1));
        chk({tag, ".lives2"}, 8'(lives2), 8'(l2));
        chk({tag, ".playing"}, 8'(playing), 8'(p));
        chk({tag, ".game_over"}, 8'(game_over), 8'(g));
        chk({tag, ".winner"}, 8'(winner), 8'(w));
    endtask

    initial begin
        // Reset with hit1 high
        @(negedge clk);
        hit1 = 1'b1;
        tick(2);
        chk_all("reset", 2'd3, 2'd3, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        tick();
        // Hits in IDLE change nothing
        hit2 = 1'b1;
        tick();
        chk_all("idle_hit", 2'd3, 2'd3, 1'b0, 1'b0, 2'b00);
        hit2 = 1'b0;
        // Start while hit1 stays high: held hit must not count
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("start", 2'd3, 2'd3, 1'b1, 1'b0, 2'b00);
        tick();
        chk("held_hit.lives1", 8'(lives1), 8'd3);
        // Single hit then cooldown
        hit1 = 1'b0;
        tick();
        hit1 = 1'b1;
        tick();
        chk("hit_a.lives1", 8'(lives1), 8'd2);
        hit1 = 1'b0;
        tick();
        hit1 = 1'b1;
        tick();
        chk("cool_drop.lives1", 8'(lives1), 8'd2);
        hit1 = 1'b0;
        tick();
        chk("cool_low.lives1", 8'(lives1), 8'd2);
        hit1 = 1'b1;
        tick();
        chk("cool_end.lives1", 8'(lives1), 8'd1);
        // start ignored in PLAY
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("start_in_play", 2'd1, 2'd3, 1'b1, 1'b0, 2'b00);
        // Final hit on player 1 -> player 2 wins
        hit1 = 1'b0;
        tick(4);
        hit1 = 1'b1;
        tick();
        chk_all("p2_wins", 2'd0, 2'd3, 1'b0, 1'b1, 2'b10);
        hit1 = 1'b0;
        tick();
        hit1 = 1'b1;
        hit2 = 1'b1;
        tick(2);
        chk_all("over_frozen", 2'd0, 2'd3, 1'b0, 1'b1, 2'b10);
        // Restart from OVER
        hit1 = 1'b0;
        hit2 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("restart", 2'd3, 2'd3, 1'b1, 1'b0, 2'b00);
        // Draw: both down to 1, then simultaneous final hits
        hit1 = 1'b1;
        hit2 = 1'b1;
        tick();
        chk_all("both_hit", 2'd2, 2'd2, 1'b1, 1'b0, 2'b00);
        hit1 = 1'b0;
        hit2 = 1'b0;
        tick(3);
        hit1 = 1'b1;
        hit2 = 1'b1;
        tick();
        chk_all("both_at_1", 2'd1, 2'd1, 1'b1, 1'b0, 2'b00);
        hit1 = 1'b0;
        hit2 = 1'b0;
        tick(3);
        hit1 = 1'b1;
        hit2 = 1'b1;
        tick();
        chk_all("draw", 2'd0, 2'd0, 1'b0, 1'b1, 2'b11);
        // Restart with a hit edge in the start cycle: edge ignored
        hit1 = 1'b0;
        hit2 = 1'b0;
        tick();
        start = 1'b1;
        hit2 = 1'b1;
        tick();
        start = 1'b0;
        chk_all("start_edge", 2'd3, 2'd3, 1'b1, 1'b0, 2'b00);
        hit2 = 1'b0;
        tick();
        hit2 = 1'b1;
        tick();
        chk_all("p2_hit", 2'd3, 2'd2, 1'b1, 1'b0, 2'b00);
        // Reset mid-cooldown
        hit2 = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk_all("mid_rst", 2'd3, 2'd3, 1'b0, 1'b0, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        hit2 = 1'b1;
        tick();
        chk_all("post_rst_hit", 2'd3, 2'd2, 1'b1, 1'b0, 2'b00);
        // Player 1 wins path: take player 2 to zero
        hit2 = 1'b0;
        tick(3);
        hit2 = 1'b1;
        tick();
        chk("p2_at_1.lives2", 8'(lives2), 8'd1);
        hit2 = 1'b0;
        tick(3);
        hit2 = 1'b1;
        tick();
        chk_all("p1_wins", 2'd3, 2'd0, 1'b0, 1'b1, 2'b01);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
